btb_next_pc: RTL and testbench

Next-PC generator for the pipelined core's fetch stage, sitting directly upstream of the stall-enabled PC register and driving its `pc_next` input every cycle. It holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. Lookup is combinational on the current fetch PC. Resolved control-flow outcomes from the execute stage update the BTB. An execute-stage redirect overrides any prediction.

---
 rtl/btb_next_pc.sv | 92 +++++++++
 tb/tb_btb_next_pc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_next_pc.sv
// Next-PC generator for the fetch stage: direct-mapped BTB with 2-bit direction
// counters, combinational lookup on pc_f and execute-stage redirect override.
module btb_next_pc #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] pc_next,
    output logic        pred_taken_f,
    output logic        pred_hit_f
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       ctr_inc;
    logic [1:0]       ctr_dec;

    // Byte-offset bits never participate in indexing or tag compare.
    logic [3:0] unused_offset_bits;
    assign unused_offset_bits = {pc_f[1:0], upd_pc[1:0]};

    assign lk_idx  = pc_f[IDX_W+1:2];
    assign lk_tag  = pc_f[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Lookup and next-PC select; state is suppressed while reset is held.
    always_comb begin
        pred_hit_f   = 1'b0;
        pred_taken_f = 1'b0;
        pc_next      = 32'(pc_f + 32'd4);
        if (!rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
            pred_hit_f   = 1'b1;
            pred_taken_f = ctr_q[lk_idx][1];
        end
        if (ex_redirect) begin
            pc_next = ex_redirect_pc;
        end else if (pred_taken_f) begin
            pc_next = target_q[lk_idx];
        end
    end

    // Saturating counter steps for the entry addressed by the update port.
    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ctr_inc = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : 2'(ctr_q[upd_idx] + 2'd1);
        ctr_dec = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : 2'(ctr_q[upd_idx] - 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_q[upd_idx]    <= ctr_inc;
                    target_q[upd_idx] <= upd_target;
                end else begin
                    ctr_q[upd_idx] <= ctr_dec;
                end
            end else if (upd_taken) begin
                // Miss with taken outcome allocates over whatever lives here.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_btb_next_pc.sv
// Bench for btb_next_pc: per-scenario stimulus rows, expected outputs queued at
// drive time and popped/compared at the following negedge.
module tb_btb_next_pc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_f = 32'h0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_redirect_pc = 32'h0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic [31:0] pc_next;
    logic        pred_taken_f;
    logic        pred_hit_f;

    int checks = 0;
    int errors = 0;

    logic [33:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic        r;
        logic [31:0] pc;
        logic        rd;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] e_pcn;
        logic        e_t;
        logic        e_h;
    } row_t;

    btb_next_pc #(.ENTRIES(16)) dut (
        .clk(clk),
        .rst(rst),
        .pc_f(pc_f),
        .ex_redirect(ex_redirect),
        .ex_redirect_pc(ex_redirect_pc),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .pc_next(pc_next),
        .pred_taken_f(pred_taken_f),
        .pred_hit_f(pred_hit_f)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(logic r, logic [31:0] pc, logic rd, logic [31:0] rpc,
                                logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                                logic [31:0] e_pcn, logic e_t, logic e_h);
        row_t x;
        x.r = r; x.pc = pc; x.rd = rd; x.rpc = rpc;
        x.uv = uv; x.upc = upc; x.ut = ut; x.utgt = utgt;
        x.e_pcn = e_pcn; x.e_t = e_t; x.e_h = e_h;
        return x;
    endfunction

    // Apply one cycle of stimulus just after the edge and queue its expected outputs.
    task automatic drive(input row_t x, input string nm);
        @(posedge clk);
        #1;
        rst            = x.r;
        pc_f           = x.pc;
        ex_redirect    = x.rd;
        ex_redirect_pc = x.rpc;
        upd_valid      = x.uv;
        upd_pc         = x.upc;
        upd_taken      = x.ut;
        upd_target     = x.utgt;
        exp_q.push_back({x.e_pcn, x.e_t, x.e_h});
        name_q.push_back(nm);
    endtask

    task automatic test_reset();
        row_t t[$];
        logic [33:0] got, want;
        string nm;
        t.push_back(mk(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'hBFC00004, 0, 0));
        t.push_back(mk(1, 32'hBFC00010, 1, 32'h80000000, 1, 32'hBFC00010, 1, 32'h12345678, 32'h80000000, 0, 0));
        t.push_back(mk(0, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'hBFC00004, 0, 0));
        t.push_back(mk(0, 32'hBFC00010, 0, 0, 0, 0, 0, 0, 32'hBFC00014, 0, 0));
        foreach (t[i]) begin
            drive(t[i], $sformatf("reset[%0d]", i));
            @(negedge clk);
            got  = {pc_next, pred_taken_f, pred_hit_f};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc_next=%h taken=%b hit=%b, expected pc_next=%h taken=%b hit=%b",
                         nm, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_alloc_alias();
        row_t t[$];
        logic [33:0] got, want;
        string nm;
        t.push_back(mk(0, 32'hBFC00010, 0, 0, 1, 32'hBFC00010, 1, 32'hBFC00100, 32'hBFC00014, 0, 0));
        t.push_back(mk(0, 32'hBFC00010, 0, 0, 0, 0, 0, 0, 32'hBFC00100, 1, 1));
        t.push_back(mk(0, 32'hBFC00050, 0, 0, 0, 0, 0, 0, 32'hBFC00054, 0, 0));
        t.push_back(mk(0, 32'hBFC00050, 0, 0, 1, 32'hBFC00050, 1, 32'hBFC00300, 32'hBFC00054, 0, 0));
        t.push_back(mk(0, 32'hBFC00050, 0, 0, 0, 0, 0, 0, 32'hBFC00300, 1, 1));
        t.push_back(mk(0, 32'hBFC00010, 0, 0, 0, 0, 0, 0, 32'hBFC00014, 0, 0));
        t.push_back(mk(0, 32'hBFC00020, 0, 0, 1, 32'hBFC00020, 0, 32'hDEAD0000, 32'hBFC00024, 0, 0));
        t.push_back(mk(0, 32'hBFC00020, 0, 0, 0, 0, 0, 0, 32'hBFC00024, 0, 0));
        foreach (t[i]) begin
            drive(t[i], $sformatf("alloc_alias[%0d]", i));
            @(negedge clk);
            got  = {pc_next, pred_taken_f, pred_hit_f};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc_next=%h taken=%b hit=%b, expected pc_next=%h taken=%b hit=%b",
                         nm, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_counter();
        row_t t[$];
        logic [33:0] got, want;
        string nm;
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 1, 32'hBFC00400, 32'hBFC00084, 0, 0));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 0, 0, 32'hBFC00400, 1, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 1, 32'hBFC00400, 32'hBFC00084, 0, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 1, 32'hBFC00400, 32'hBFC00400, 1, 1));
        for (int k = 0; k < 4; k++)
            t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 1, 32'hBFC00400, 32'hBFC00400, 1, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 0, 0, 32'hBFC00400, 1, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 0, 0, 32'hBFC00400, 1, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 0, 0, 0, 0, 32'hBFC00084, 0, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 0, 0, 32'hBFC00084, 0, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 0, 0, 32'hBFC00084, 0, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 1, 32'hBFC00500, 32'hBFC00084, 0, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 1, 32'hBFC00080, 1, 32'hBFC00600, 32'hBFC00084, 0, 1));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 0, 0, 0, 0, 32'hBFC00600, 1, 1));
        foreach (t[i]) begin
            drive(t[i], $sformatf("counter[%0d]", i));
            @(negedge clk);
            got  = {pc_next, pred_taken_f, pred_hit_f};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc_next=%h taken=%b hit=%b, expected pc_next=%h taken=%b hit=%b",
                         nm, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_redirect();
        row_t t[$];
        logic [33:0] got, want;
        string nm;
        t.push_back(mk(0, 32'hBFC00050, 1, 32'hBFC00200, 1, 32'hBFC00050, 1, 32'hBFC00700, 32'hBFC00200, 1, 1));
        t.push_back(mk(0, 32'hBFC00050, 0, 0, 0, 0, 0, 0, 32'hBFC00700, 1, 1));
        t.push_back(mk(0, 32'hBFC000C0, 1, 32'h00001000, 0, 0, 0, 0, 32'h00001000, 0, 0));
        foreach (t[i]) begin
            drive(t[i], $sformatf("redirect[%0d]", i));
            @(negedge clk);
            got  = {pc_next, pred_taken_f, pred_hit_f};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc_next=%h taken=%b hit=%b, expected pc_next=%h taken=%b hit=%b",
                         nm, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t t[$];
        logic [33:0] got, want;
        string nm;
        t.push_back(mk(0, 32'hBFC00104, 0, 0, 1, 32'hBFC00104, 1, 32'h00010000, 32'hBFC00108, 0, 0));
        t.push_back(mk(0, 32'hBFC00104, 0, 0, 1, 32'hBFC00108, 1, 32'h00020000, 32'h00010000, 1, 1));
        t.push_back(mk(0, 32'hBFC00108, 0, 0, 0, 0, 0, 0, 32'h00020000, 1, 1));
        foreach (t[i]) begin
            drive(t[i], $sformatf("back_to_back[%0d]", i));
            @(negedge clk);
            got  = {pc_next, pred_taken_f, pred_hit_f};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc_next=%h taken=%b hit=%b, expected pc_next=%h taken=%b hit=%b",
                         nm, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_flush_wrap();
        row_t t[$];
        logic [33:0] got, want;
        string nm;
        t.push_back(mk(1, 32'hBFC00050, 0, 0, 0, 0, 0, 0, 32'hBFC00054, 0, 0));
        t.push_back(mk(0, 32'hBFC00050, 0, 0, 0, 0, 0, 0, 32'hBFC00054, 0, 0));
        t.push_back(mk(0, 32'hBFC00104, 0, 0, 0, 0, 0, 0, 32'hBFC00108, 0, 0));
        t.push_back(mk(0, 32'hBFC00108, 0, 0, 0, 0, 0, 0, 32'hBFC0010C, 0, 0));
        t.push_back(mk(0, 32'hBFC00080, 0, 0, 0, 0, 0, 0, 32'hBFC00084, 0, 0));
        t.push_back(mk(0, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0));
        foreach (t[i]) begin
            drive(t[i], $sformatf("flush_wrap[%0d]", i));
            @(negedge clk);
            got  = {pc_next, pred_taken_f, pred_hit_f};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc_next=%h taken=%b hit=%b, expected pc_next=%h taken=%b hit=%b",
                         nm, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alloc_alias();
        test_counter();
        test_redirect();
        test_back_to_back();
        test_flush_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
